rr_code_arbiter: RTL and testbench
==================================

Name: rr_code_arbiter

Overview:
- Round-robin arbiter that picks one of four requesters and emits the winner as a registered 2-bit binary code plus a valid flag.
- Sits directly upstream of decoder_2to4. code drives the decoder's code input. The decoder's 4-bit one-hot out, qualified by valid, becomes the per-unit enable/select.
- Supports bounded burst ownership (MAX_HOLD) and an owner lock, so one requester cannot starve the others.

Parameters:
- MAX_HOLD, 4, max consecutive grant cycles before forced rotation if another requester is waiting; legal range 1..255.
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request vector; bit i = requester i.
- lock  input  1  when 1, the current owner keeps the grant regardless of the hold count.
- code  output  2  registered binary index of the granted requester.
- valid  output  1  registered; 1 = code is a live grant.
- hold_cnt  output  CNT_W  cycles the current owner has held the grant, saturating at MAX_HOLD.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high (rst).
- Reset values, applied immediately on rst=1: code=2'b00, valid=0, hold_cnt=0, priority pointer ptr=0, state=IDLE. rst asserted mid-grant drops valid immediately with no completion of the burst.
- State machine: two states, IDLE and GRANT. All outputs are registered.
- Search function pick(start): the first set bit of req scanning start, start+1, ... mod 4.
- IDLE:
  - req==0: stay in IDLE; valid=0; code holds its last value.
  - req!=0: next edge code=pick(ptr), valid=1, hold_cnt=1, go to GRANT.
  - Latency from req to valid is 1 cycle.
- GRANT, owner o=code, others = req with bit o masked. Rules in priority order:
  1. req[o]==0 (release): if others!=0, next edge code=pick(o+1), hold_cnt=1, stay in GRANT (no bubble). Else valid=0, hold_cnt=0, go to IDLE. ptr=o+1 mod 4 in both cases.
  2. lock==1: keep o; hold_cnt increments, saturating at MAX_HOLD.
  3. hold_cnt==MAX_HOLD and others!=0 (forced rotation): code=pick(o+1), hold_cnt=1, ptr=o+1 mod 4.
  4. Otherwise keep o; hold_cnt increments, saturating at MAX_HOLD.
- Wrap-around: all index arithmetic is mod 4. pick(4) is pick(0), so after owner 3 the search starts at 0.
- Grant changes occur only at clock edges. code never changes while valid=1 unless a rule above fires.
- The downstream decoder output is meaningful only when valid=1.
- Simultaneous release by the owner and a new request from another requester on the same cycle: rule 1 applies, and the new requester is eligible in that same pick.
- lock is ignored in IDLE; it does not create a grant.
- MAX_HOLD=1: rotation after every cycle whenever others are waiting.

Test Plan:
- Reset then req=4'b0000 for 3 cycles -> valid=0, code=00, hold_cnt=0 throughout. Assert rst mid-grant -> valid=0 before the next edge.
- req=4'b0100 from IDLE -> 1 cycle later valid=1, code=10, hold_cnt=1. Drop req -> next edge valid=0, ptr=3.
- req=4'b1111 held, lock=0, MAX_HOLD=4 -> code sequence 00 x4, 01 x4, 10 x4, 11 x4, then 00 (wrap); hold_cnt runs 1..4 each burst.
- Owner 1 with req=4'b0010 held for 10 cycles, no others -> code stays 01, hold_cnt saturates at 4. Then assert req[3] -> next edge code=11, hold_cnt=1.
- Owner 0 with lock=1 and req=4'b1011 for 8 cycles -> code stays 00, hold_cnt=4. Drop lock -> next edge code=01.
- Owner 2 drops req[2] in the same cycle req[0] rises (req=4'b0001) -> next edge code=00, valid stays 1 (no bubble). Drive code into decoder_2to4 -> out=4'b0001.

Source files
------------

// File: rtl/rr_code_arbiter.sv
// rtl/rr_code_arbiter.sv - four-way round-robin arbiter with registered binary grant code
// Bounded burst ownership (MAX_HOLD) with an owner lock; feeds a 2-to-4 decoder.
module rr_code_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic             lock,
  output logic [1:0]       code,
  output logic             valid,
  output logic [CNT_W-1:0] hold_cnt
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_ONE = CNT_W'(1);

  logic [0:0]       state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  logic [3:0]       others;
  logic [1:0]       next_idx;
  logic [CNT_W-1:0] hold_inc;

  // First set bit of r scanning start, start+1, ... with 2-bit wrap.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] idx;
    logic       found;
    pick  = start;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = start + 2'(k);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  always_comb begin
    others           = req;
    others[code_q]   = 1'b0;
    next_idx         = code_q + 2'd1;
    hold_inc         = (hold_cnt_q < HOLD_MAX) ? hold_cnt_q + HOLD_ONE : HOLD_MAX;

    state_d    = state_q;
    ptr_d      = ptr_q;
    code_d     = code_q;
    valid_d    = valid_q;
    hold_cnt_d = hold_cnt_q;

    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        if (req != 4'b0000) begin
          code_d     = pick(req, ptr_q);
          valid_d    = 1'b1;
          hold_cnt_d = HOLD_ONE;
          state_d    = ST_GRANT;
        end
      end
      default: begin
        if (!req[code_q]) begin
          ptr_d = next_idx;
          if (others != 4'b0000) begin
            code_d     = pick(others, next_idx);
            hold_cnt_d = HOLD_ONE;
          end else begin
            valid_d    = 1'b0;
            hold_cnt_d = '0;
            state_d    = ST_IDLE;
          end
        end else if (lock) begin
          hold_cnt_d = hold_inc;
        end else if (hold_cnt_q == HOLD_MAX && others != 4'b0000) begin
          code_d     = pick(others, next_idx);
          hold_cnt_d = HOLD_ONE;
          ptr_d      = next_idx;
        end else begin
          hold_cnt_d = hold_inc;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= 2'd0;
      code_q     <= 2'd0;
      valid_q    <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign code     = code_q;
  assign valid    = valid_q;
  assign hold_cnt = hold_cnt_q;

endmodule

// File: tb/tb_rr_code_arbiter.sv
// tb/tb_rr_code_arbiter.sv - directed and randomized checks of rr_code_arbiter
// Expected values come from a reference model of the arbitration rules.
module tb_rr_code_arbiter;

  localparam int MAX_HOLD = 4;
  localparam int CNT_W    = 8;

  logic             clk;
  logic             rst;
  logic [3:0]       req;
  logic             lock;
  logic [1:0]       code;
  logic             valid;
  logic [CNT_W-1:0] hold_cnt;

  int checks;
  int fails;

  int m_code;
  int m_valid;
  int m_hold;
  int m_ptr;

  rr_code_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .lock     (lock),
    .code     (code),
    .valid    (valid),
    .hold_cnt (hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pick_m(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  function automatic int sat(input int v);
    return (v > MAX_HOLD) ? MAX_HOLD : v;
  endfunction

  task automatic model_reset();
    m_code  = 0;
    m_valid = 0;
    m_hold  = 0;
    m_ptr   = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic l);
    logic [3:0] oth;
    int o;
    if (m_valid == 0) begin
      if (r != 4'b0000) begin
        m_code  = pick_m(r, m_ptr);
        m_valid = 1;
        m_hold  = 1;
      end
    end else begin
      o      = m_code;
      oth    = r;
      oth[o] = 1'b0;
      if (!r[o]) begin
        m_ptr = (o + 1) % 4;
        if (oth != 4'b0000) begin
          m_code = pick_m(oth, (o + 1) % 4);
          m_hold = 1;
        end else begin
          m_valid = 0;
          m_hold  = 0;
        end
      end else if (l) begin
        m_hold = sat(m_hold + 1);
      end else if (m_hold == MAX_HOLD && oth != 4'b0000) begin
        m_code = pick_m(oth, (o + 1) % 4);
        m_hold = 1;
        m_ptr  = (o + 1) % 4;
      end else begin
        m_hold = sat(m_hold + 1);
      end
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".valid"}, int'(valid), m_valid);
    chk({tag, ".code"}, int'(code), m_code);
    chk({tag, ".hold"}, int'(hold_cnt), m_hold);
  endtask

  task automatic step(input logic [3:0] r, input logic l, input string tag);
    req  = r;
    lock = l;
    @(posedge clk);
    model_step(r, l);
    #1;
    chk_model(tag);
  endtask

  initial begin
    logic [3:0] dec;
    logic [3:0] rr;
    checks = 0;
    fails  = 0;
    rst    = 1'b1;
    req    = 4'b0000;
    lock   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_model("reset");

    for (int i = 0; i < 3; i++) step(4'b0000, 1'b0, "idle");
    chk("idle_code", int'(code), 0);

    step(4'b0100, 1'b0, "single");
    chk("single_valid", int'(valid), 1);
    chk("single_code", int'(code), 2);
    chk("single_hold", int'(hold_cnt), 1);
    step(4'b0000, 1'b0, "drop");
    chk("drop_valid", int'(valid), 0);
    step(4'b1111, 1'b0, "ptr3");
    chk("ptr3_code", int'(code), 3);
    step(4'b1111, 1'b0, "pre_rst");

    #1 rst = 1'b1;
    #1;
    model_reset();
    chk_model("async_rst");
    #2 rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      step(4'b1111, 1'b0, "rr_all");
      chk("rr_code", int'(code), (i / 4) % 4);
      chk("rr_hold", int'(hold_cnt), (i % 4) + 1);
    end
    step(4'b1111, 1'b0, "rr_wrap");
    chk("rr_wrap_code", int'(code), 0);

    for (int i = 0; i < 10; i++) step(4'b0010, 1'b0, "solo1");
    chk("solo1_code", int'(code), 1);
    chk("solo1_hold", int'(hold_cnt), MAX_HOLD);
    step(4'b1010, 1'b0, "solo1_rot");
    chk("solo1_rot_code", int'(code), 3);
    chk("solo1_rot_hold", int'(hold_cnt), 1);

    step(4'b0001, 1'b0, "to0");
    for (int i = 0; i < 8; i++) step(4'b1011, 1'b1, "lock0");
    chk("lock0_code", int'(code), 0);
    chk("lock0_hold", int'(hold_cnt), MAX_HOLD);
    step(4'b1011, 1'b0, "unlock");
    chk("unlock_code", int'(code), 1);

    step(4'b0100, 1'b0, "to2");
    chk("to2_code", int'(code), 2);
    step(4'b0001, 1'b0, "handoff");
    chk("handoff_valid", int'(valid), 1);
    chk("handoff_code", int'(code), 0);
    dec = 4'b0001 << code;
    chk("decoder_out", int'(dec), 1);

    step(4'b0000, 1'b0, "idle_lock_a");
    step(4'b0000, 1'b1, "idle_lock_b");
    chk("idle_lock_valid", int'(valid), 0);

    for (int i = 0; i < 400; i++) begin
      rr = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) rr = 4'b0000;
      step(rr, ($urandom_range(0, 3) == 0), "random");
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
